// File: rtl/lsu_data_memory.sv
// rtl/lsu_data_memory.sv - RV32 byte/half/word load-store data memory with wait states
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of forcing alignment).
module lsu_data_memory #(
    parameter int DATA_DEPTH  = 128,
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  ready,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  err
);
    localparam int IDX_W = $clog2(DATA_DEPTH);
    localparam int LA_W  = IDX_W + 2;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    logic            state;
    logic [3:0]      count;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [LA_W-1:0] addr_q;
    logic [31:0]     wdata_q;

    logic            commit;
    logic            c_we;
    logic [1:0]      c_size;
    logic            c_uns;
    logic [LA_W-1:0] c_addr;
    logic [31:0]     c_wdata;
    logic [LA_W-1:0] a_eff;
    logic            trap;
    logic            is_byte;
    logic            is_half;
    logic [IDX_W-1:0] idx;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic [31:0]     rd_word;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [31:0]     ld_val;
    logic            unused_addr_bits;

    logic [31:0] mem [DATA_DEPTH];

    // Bits above the word index only alias the same storage.
    assign unused_addr_bits = ^addr[ADDR_WIDTH-1:LA_W];

    assign ready = (state == ST_IDLE);

    // With no wait states the access commits on the accept edge straight from the ports.
    assign commit  = (WAIT_STATES == 0) ? (ready && req) : (state == ST_WAIT && count == 4'd0);
    assign c_we    = (WAIT_STATES == 0) ? we          : we_q;
    assign c_size  = (WAIT_STATES == 0) ? size        : size_q;
    assign c_uns   = (WAIT_STATES == 0) ? unsigned_ld : uns_q;
    assign c_addr  = (WAIT_STATES == 0) ? addr[LA_W-1:0] : addr_q;
    assign c_wdata = (WAIT_STATES == 0) ? wdata       : wdata_q;

    assign is_byte = (c_size == 2'b00);
    assign is_half = (c_size == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap  = (is_half && c_addr[0]) || (!is_byte && !is_half && c_addr[1:0] != 2'b00);
    assign a_eff = c_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else begin
            err <= commit && trap;
        end
    end
`else
    assign trap = 1'b0;
    assign err  = 1'b0;

    always_comb begin
        a_eff = c_addr;
        if (is_half) begin
            a_eff[0] = 1'b0;
        end else if (!is_byte) begin
            a_eff[1:0] = 2'b00;
        end
    end
`endif

    assign idx = a_eff[LA_W-1:2];

    always_comb begin
        be = 4'hF;
        wd = c_wdata;
        if (is_byte) begin
            be = 4'b0001 << a_eff[1:0];
            wd = {4{c_wdata[7:0]}};
        end else if (is_half) begin
            be = a_eff[1] ? 4'b1100 : 4'b0011;
            wd = {2{c_wdata[15:0]}};
        end
    end

    always_comb begin
        rd_word = mem[idx];
        ld_b    = rd_word[{a_eff[1:0], 3'b000} +: 8];
        ld_h    = rd_word[{a_eff[1], 4'b0000} +: 16];
        if (is_byte) begin
            ld_val = {{24{~c_uns & ld_b[7]}}, ld_b};
        end else if (is_half) begin
            ld_val = {{16{~c_uns & ld_h[15]}}, ld_h};
        end else begin
            ld_val = rd_word;
        end
    end

    // Storage is not reset; the reset gate keeps a reset edge from landing a write.
    always_ff @(posedge clk) begin
        if (reset && commit && c_we && !trap) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count   <= 4'd0;
            done    <= 1'b0;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            done <= commit;
            if (commit && !c_we && !trap) begin
                rdata <= ld_val;
            end
            if (state == ST_IDLE) begin
                if (req) begin
                    we_q    <= we;
                    size_q  <= size;
                    uns_q   <= unsigned_ld;
                    addr_q  <= addr[LA_W-1:0];
                    wdata_q <= wdata;
                    if (WAIT_STATES != 0) begin
                        state <= ST_WAIT;
                        count <= 4'(WAIT_STATES - 1);
                    end
                end
            end else begin
                if (count == 4'd0) begin
                    state <= ST_IDLE;
                end else begin
                    count <= count - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_data_memory.sv
// tb/tb_lsu_data_memory.sv - directed self-checking bench for lsu_data_memory
module tb_lsu_data_memory;
    localparam int WS = 1;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_data_memory #(.DATA_DEPTH(128), .ADDR_WIDTH(16), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access; reports done latency in negedges after accept, ready during the first
    // post-accept cycle, and err at the done cycle. lat=0 means timeout.
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [15:0] a, input logic [31:0] d,
                          output int lat, output logic rdy_first, output logic err_done);
        @(negedge clk);
        we = w; size = sz; unsigned_ld = u; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        rdy_first = 1'bx;
        err_done = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) rdy_first = ready;
            if (done) begin
                lat = i;
                err_done = err;
                break;
            end
        end
        n_checks++;
        if (lat == 0) begin
            $display("FAIL access_timeout addr=%h: no done within 20 cycles", a);
            n_fail++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
        addr = 16'h0; wdata = 32'h0;
        #12;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin $display("FAIL reset_ready got %b exp 1", ready); n_fail++; end
        n_checks++; if (done !== 1'b0) begin $display("FAIL reset_done got %b exp 0", done); n_fail++; end
        n_checks++; if (err !== 1'b0) begin $display("FAIL reset_err got %b exp 0", err); n_fail++; end
        n_checks++; if (rdata !== 32'h0) begin $display("FAIL reset_rdata got %h exp 00000000", rdata); n_fail++; end
        reset = 1'b1;
    endtask

    task automatic test_word;
        int lat; logic rf; logic e;
        access(1'b1, 2'b10, 1'b0, 16'h0008, 32'hDEADBEEF, lat, rf, e);
        n_checks++; if (lat != WS + 1) begin $display("FAIL sw_latency got %0d exp %0d", lat, WS + 1); n_fail++; end
        n_checks++; if (rf !== 1'b0) begin $display("FAIL sw_ready_in_wait got %b exp 0", rf); n_fail++; end
        n_checks++; if (ready !== 1'b1) begin $display("FAIL sw_ready_at_done got %b exp 1", ready); n_fail++; end
        access(1'b0, 2'b10, 1'b0, 16'h0008, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'hDEADBEEF) begin $display("FAIL lw_08 got %h exp DEADBEEF", rdata); n_fail++; end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin $display("FAIL done_one_cycle got %b exp 0", done); n_fail++; end
        n_checks++; if (rdata !== 32'hDEADBEEF) begin $display("FAIL rdata_hold got %h exp DEADBEEF", rdata); n_fail++; end
    endtask

    task automatic test_byte;
        int lat; logic rf; logic e;
        access(1'b1, 2'b10, 1'b0, 16'h000C, 32'h11223344, lat, rf, e);
        access(1'b1, 2'b00, 1'b0, 16'h000D, 32'hFFFFFF80, lat, rf, e);
        access(1'b0, 2'b10, 1'b0, 16'h000C, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'h11228044) begin $display("FAIL sb_word got %h exp 11228044", rdata); n_fail++; end
        access(1'b0, 2'b00, 1'b0, 16'h000D, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'hFFFFFF80) begin $display("FAIL lb got %h exp FFFFFF80", rdata); n_fail++; end
        access(1'b0, 2'b00, 1'b1, 16'h000D, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'h00000080) begin $display("FAIL lbu got %h exp 00000080", rdata); n_fail++; end
        access(1'b0, 2'b00, 1'b0, 16'h000F, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'h00000011) begin $display("FAIL lb_lane3 got %h exp 00000011", rdata); n_fail++; end
    endtask

    task automatic test_half;
        int lat; logic rf; logic e;
        access(1'b1, 2'b10, 1'b0, 16'h0010, 32'h33334444, lat, rf, e);
        access(1'b1, 2'b01, 1'b0, 16'h0012, 32'h00008001, lat, rf, e);
        access(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'hFFFF8001) begin $display("FAIL lh got %h exp FFFF8001", rdata); n_fail++; end
        access(1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'h00008001) begin $display("FAIL lhu got %h exp 00008001", rdata); n_fail++; end
        access(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'h80014444) begin $display("FAIL sh_word got %h exp 80014444", rdata); n_fail++; end
        access(1'b0, 2'b01, 1'b0, 16'h0010, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'h00004444) begin $display("FAIL lh_low got %h exp 00004444", rdata); n_fail++; end
    endtask

    task automatic test_wrap;
        int lat; logic rf; logic e;
        access(1'b1, 2'b10, 1'b0, 16'h0200, 32'hA5A5A5A5, lat, rf, e);
        n_checks++; if (rdata !== 32'h00004444) begin $display("FAIL store_keeps_rdata got %h exp 00004444", rdata); n_fail++; end
        access(1'b0, 2'b10, 1'b0, 16'h0000, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'hA5A5A5A5) begin $display("FAIL wrap got %h exp A5A5A5A5", rdata); n_fail++; end
    endtask

    task automatic test_reset_mid_wait;
        int lat; logic rf; logic e; logic seen_done;
        access(1'b1, 2'b10, 1'b0, 16'h0020, 32'h55555555, lat, rf, e);
        @(negedge clk);
        we = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 16'h0020; wdata = 32'hCAFEF00D; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        #2 reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || err) seen_done = 1'b1;
        end
        n_checks++; if (ready !== 1'b1) begin $display("FAIL midreset_ready got %b exp 1", ready); n_fail++; end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || err) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) begin $display("FAIL midreset_done got %b exp 0", seen_done); n_fail++; end
        access(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'h55555555) begin $display("FAIL midreset_mem got %h exp 55555555", rdata); n_fail++; end
    endtask

    task automatic test_misalign;
        int lat; logic rf; logic e;
        access(1'b1, 2'b10, 1'b0, 16'h0004, 32'h01020304, lat, rf, e);
        access(1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, lat, rf, e);
        access(1'b0, 2'b10, 1'b0, 16'h0006, 32'h0, lat, rf, e);
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++; if (e !== 1'b1) begin $display("FAIL misalign_err got %b exp 1", e); n_fail++; end
        n_checks++; if (rdata !== 32'h55555555) begin $display("FAIL misalign_rdata got %h exp 55555555", rdata); n_fail++; end
        @(negedge clk);
        n_checks++; if (err !== 1'b0) begin $display("FAIL err_one_cycle got %b exp 0", err); n_fail++; end
`else
        n_checks++; if (e !== 1'b0) begin $display("FAIL misalign_err got %b exp 0", e); n_fail++; end
        n_checks++; if (rdata !== 32'h01020304) begin $display("FAIL misalign_rdata got %h exp 01020304", rdata); n_fail++; end
        access(1'b0, 2'b01, 1'b1, 16'h0007, 32'h0, lat, rf, e);
        n_checks++; if (rdata !== 32'h00000102) begin $display("FAIL misalign_lhu got %h exp 00000102", rdata); n_fail++; end
`endif
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        we = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 16'h0030; wdata = 32'h0BADCAFE; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready !== 1'b0 || done !== 1'b0) begin $display("FAIL b2b_wait1 got ready=%b done=%b exp 0 0", ready, done); n_fail++; end
        we = 1'b0; wdata = 32'h0;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1 || done !== 1'b1) begin $display("FAIL b2b_store_done got ready=%b done=%b exp 1 1", ready, done); n_fail++; end
        @(negedge clk);
        n_checks++; if (ready !== 1'b0 || done !== 1'b0) begin $display("FAIL b2b_wait2 got ready=%b done=%b exp 0 0", ready, done); n_fail++; end
        @(negedge clk);
        req = 1'b0;
        n_checks++; if (done !== 1'b1) begin $display("FAIL b2b_load_done got %b exp 1", done); n_fail++; end
        n_checks++; if (rdata !== 32'h0BADCAFE) begin $display("FAIL b2b_raw got %h exp 0BADCAFE", rdata); n_fail++; end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_wrap();
        test_reset_mid_wait();
        test_misalign();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
